// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: walks one active-low column per scan tick and
// debounces both press and release before reporting a key code.
module keypad_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pressed
);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [7:0]  CNT_MAX  = 8'(DEBOUNCE_CNT);

  // Returns {valid, index}; valid only when exactly one row line is low.
  function automatic logic [2:0] decode_row(input logic [3:0] r);
    logic [2:0] res;
    case (r)
      4'b1110: res = 3'b100;
      4'b1101: res = 3'b101;
      4'b1011: res = 3'b110;
      4'b0111: res = 3'b111;
      default: res = 3'b000;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] c);
    return ~(4'b0001 << c);
  endfunction

  function automatic logic [7:0] cnt_inc(input logic [7:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 8'd1;
  endfunction

  logic [3:0]  row_meta_r;
  logic [3:0]  rs_r;
  logic [15:0] div_r;
  logic        tick_s;
  state_t      state_r, state_s;
  logic [1:0]  c_r, c_s;
  logic [1:0]  r_r, r_s;
  logic [3:0]  pat_r, pat_s;
  logic [7:0]  cnt_r, cnt_s;
  logic [3:0]  col_r, col_s;
  logic [3:0]  key_code_r, key_code_s;
  logic        key_valid_r, key_valid_s;
  logic        key_pressed_r, key_pressed_s;
  logic [2:0]  hit_s;
  logic [7:0]  inc_s;

  // Two-flop synchronizer for the asynchronous row lines.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      row_meta_r <= 4'b1111;
      rs_r       <= 4'b1111;
    end else begin
      row_meta_r <= row;
      rs_r       <= row_meta_r;
    end
  end

  // Free-running scan-tick divider.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      div_r <= 16'd0;
    end else if (div_r == DIV_LAST) begin
      div_r <= 16'd0;
    end else begin
      div_r <= div_r + 16'd1;
    end
  end

  assign tick_s = (div_r == DIV_LAST);

  // FSM and output register bank.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_r       <= ST_SCAN;
      c_r           <= 2'd0;
      r_r           <= 2'd0;
      pat_r         <= 4'b1111;
      cnt_r         <= 8'd0;
      col_r         <= 4'b1110;
      key_code_r    <= 4'h0;
      key_valid_r   <= 1'b0;
      key_pressed_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      c_r           <= c_s;
      r_r           <= r_s;
      pat_r         <= pat_s;
      cnt_r         <= cnt_s;
      col_r         <= col_s;
      key_code_r    <= key_code_s;
      key_valid_r   <= key_valid_s;
      key_pressed_r <= key_pressed_s;
    end
  end

  // Next-state logic; the FSM only samples rs on a scan tick.
  always_comb begin
    state_s       = state_r;
    c_s           = c_r;
    r_s           = r_r;
    pat_s         = pat_r;
    cnt_s         = cnt_r;
    col_s         = col_r;
    key_code_s    = key_code_r;
    key_valid_s   = 1'b0;
    key_pressed_s = key_pressed_r;
    hit_s         = decode_row(rs_r);
    inc_s         = cnt_inc(cnt_r);
    if (tick_s) begin
      case (state_r)
        ST_SCAN: begin
          if (hit_s[2]) begin
            r_s     = hit_s[1:0];
            pat_s   = rs_r;
            cnt_s   = 8'd0;
            state_s = ST_DEBOUNCE;
          end else begin
            c_s   = c_r + 2'd1;
            col_s = col_drive(c_r + 2'd1);
          end
        end
        ST_DEBOUNCE: begin
          if (rs_r == pat_r) begin
            cnt_s = inc_s;
            if (inc_s == CNT_MAX) begin
              state_s       = ST_PRESSED;
              key_code_s    = {r_r, c_r};
              key_valid_s   = 1'b1;
              key_pressed_s = 1'b1;
            end else begin
              state_s = ST_DEBOUNCE;
            end
          end else begin
            cnt_s   = 8'd0;
            state_s = ST_SCAN;
          end
        end
        ST_PRESSED: begin
          if (rs_r == 4'b1111) begin
            cnt_s   = 8'd0;
            state_s = ST_RELEASE;
          end else begin
            state_s = ST_PRESSED;
          end
        end
        ST_RELEASE: begin
          if (rs_r == 4'b1111) begin
            cnt_s = inc_s;
            if (inc_s == CNT_MAX) begin
              key_pressed_s = 1'b0;
              state_s       = ST_SCAN;
            end else begin
              state_s = ST_RELEASE;
            end
          end else begin
            cnt_s   = 8'd0;
            state_s = ST_RELEASE;
          end
        end
        default: begin
          state_s = ST_SCAN;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  assign col         = col_r;
  assign key_code    = key_code_r;
  assign key_valid   = key_valid_r;
  assign key_pressed = key_pressed_r;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed testbench for keypad_scan with a behavioural 4x4 keypad model.
module tb_keypad_scan;
  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;

  logic       CLK  = 1'b0;
  logic       RSTn = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_pressed;

  logic       key_down = 1'b0;
  int         kr = 0;
  int         kc = 0;
  logic       row_force = 1'b0;
  logic [3:0] row_force_val = 4'hF;

  int n_cmp = 0;
  int n_bad = 0;
  int vcount = 0;
  int width_err = 0;
  int code_err = 0;
  logic       prev_valid = 1'b0;
  logic [3:0] prev_code = 4'h0;

  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT)) dut (
    .CLK(CLK), .RSTn(RSTn), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_pressed(key_pressed)
  );

  always #5 CLK = ~CLK;

  // Keypad model: a held key pulls its row low only while its column is driven.
  always_comb begin
    if (row_force) row = row_force_val;
    else if (key_down && col[kc] == 1'b0) row = ~(4'b0001 << kr);
    else row = 4'hF;
  end

  // Strobe counter plus strobe-width and code-stability tracking.
  always @(posedge CLK) begin
    #1;
    if (RSTn) begin
      if (key_valid === 1'b1) vcount++;
      if (key_valid === 1'b1 && prev_valid === 1'b1) width_err++;
      if (key_code !== prev_code && key_valid !== 1'b1) code_err++;
    end
    prev_valid = key_valid;
    prev_code  = key_code;
  end

  task automatic wait_change(output int cyc);
    logic [3:0] prev;
    prev = col;
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (col === prev && cyc < 40);
  endtask

  task automatic align_col(input logic [3:0] target);
    int cyc;
    int guard;
    guard = 0;
    do begin
      wait_change(cyc);
      guard++;
    end while (col !== target && guard < 8);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (key_valid !== 1'b1 && cyc < 200);
  endtask

  task automatic wait_release();
    int cyc;
    cyc = 0;
    while (key_pressed === 1'b1 && cyc < 200) begin
      @(negedge CLK);
      cyc++;
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_col [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    int cyc;
    RSTn = 1'b0;
    key_down = 1'b0;
    repeat (3) @(negedge CLK);
    n_cmp++; if (col !== 4'b1110) begin n_bad++; $display("FAIL reset_col: got %b want 1110", col); end
    n_cmp++; if (key_code !== 4'h0) begin n_bad++; $display("FAIL reset_code: got %h want 0", key_code); end
    n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", key_valid); end
    n_cmp++; if (key_pressed !== 1'b0) begin n_bad++; $display("FAIL reset_pressed: got %b want 0", key_pressed); end
    RSTn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_change(cyc);
      n_cmp++; if (col !== exp_col[i]) begin n_bad++; $display("FAIL walk_col[%0d]: got %b want %b", i, col, exp_col[i]); end
      n_cmp++; if (cyc != SCAN_DIV) begin n_bad++; $display("FAIL walk_period[%0d]: got %0d want %0d", i, cyc, SCAN_DIV); end
    end
  endtask

  task automatic test_clean_press();
    int cyc;
    int v0;
    align_col(4'b1011);
    v0 = vcount;
    kr = 1; kc = 2; key_down = 1'b1;
    wait_valid(cyc);
    n_cmp++; if (cyc != 16) begin n_bad++; $display("FAIL press_latency: got %0d want 16", cyc); end
    n_cmp++; if (key_code !== 4'h6) begin n_bad++; $display("FAIL press_code: got %h want 6", key_code); end
    n_cmp++; if (key_pressed !== 1'b1) begin n_bad++; $display("FAIL press_held: got %b want 1", key_pressed); end
    repeat (40) @(negedge CLK);
    n_cmp++; if (vcount - v0 != 1) begin n_bad++; $display("FAIL press_strobes: got %0d want 1", vcount - v0); end
    key_down = 1'b0;
    repeat (12) @(negedge CLK);
    n_cmp++; if (key_pressed !== 1'b1) begin n_bad++; $display("FAIL release_hold: got %b want 1", key_pressed); end
    repeat (4) @(negedge CLK);
    n_cmp++; if (key_pressed !== 1'b0) begin n_bad++; $display("FAIL release_done: got %b want 0", key_pressed); end
    n_cmp++; if (col !== 4'b1011) begin n_bad++; $display("FAIL release_col: got %b want 1011", col); end
    repeat (4) @(negedge CLK);
    n_cmp++; if (col !== 4'b0111) begin n_bad++; $display("FAIL resume_col: got %b want 0111", col); end
  endtask

  task automatic test_bounce();
    int cyc;
    int v0;
    align_col(4'b1011);
    v0 = vcount;
    kr = 1; kc = 2;
    for (int i = 0; i < 5; i++) begin
      key_down = (i % 2 == 0);
      repeat (4) @(negedge CLK);
    end
    n_cmp++; if (vcount != v0) begin n_bad++; $display("FAIL bounce_quiet: got %0d strobes want 0", vcount - v0); end
    wait_valid(cyc);
    n_cmp++; if (cyc != 12) begin n_bad++; $display("FAIL bounce_latency: got %0d want 12", cyc); end
    n_cmp++; if (key_code !== 4'h6) begin n_bad++; $display("FAIL bounce_code: got %h want 6", key_code); end
    n_cmp++; if (vcount - v0 != 1) begin n_bad++; $display("FAIL bounce_strobes: got %0d want 1", vcount - v0); end
    key_down = 1'b0;
    wait_release();
    n_cmp++; if (key_pressed !== 1'b0) begin n_bad++; $display("FAIL bounce_release: got %b want 0", key_pressed); end
  endtask

  task automatic test_multi_row();
    int cyc;
    int v0;
    logic [3:0] prev;
    wait_change(cyc);
    v0 = vcount;
    row_force_val = 4'b1100;
    row_force = 1'b1;
    for (int i = 0; i < 4; i++) begin
      prev = col;
      repeat (4) @(negedge CLK);
      n_cmp++; if (col !== {prev[2:0], prev[3]}) begin n_bad++; $display("FAIL multi_walk[%0d]: got %b want %b", i, col, {prev[2:0], prev[3]}); end
    end
    n_cmp++; if (vcount != v0) begin n_bad++; $display("FAIL multi_strobes: got %0d want 0", vcount - v0); end
    row_force = 1'b0;
  endtask

  task automatic test_key15_twice();
    int cyc;
    int v0;
    align_col(4'b0111);
    v0 = vcount;
    kr = 3; kc = 3; key_down = 1'b1;
    wait_valid(cyc);
    n_cmp++; if (key_code !== 4'hF) begin n_bad++; $display("FAIL k15_code1: got %h want F", key_code); end
    key_down = 1'b0;
    wait_release();
    key_down = 1'b1;
    wait_valid(cyc);
    n_cmp++; if (key_code !== 4'hF) begin n_bad++; $display("FAIL k15_code2: got %h want F", key_code); end
    n_cmp++; if (vcount - v0 != 2) begin n_bad++; $display("FAIL k15_strobes: got %0d want 2", vcount - v0); end
    key_down = 1'b0;
    repeat (8) @(negedge CLK);
    key_down = 1'b1;
    repeat (4) @(negedge CLK);
    key_down = 1'b0;
    repeat (8) @(negedge CLK);
    n_cmp++; if (key_pressed !== 1'b1) begin n_bad++; $display("FAIL glitch_hold: got %b want 1", key_pressed); end
    repeat (4) @(negedge CLK);
    n_cmp++; if (key_pressed !== 1'b0) begin n_bad++; $display("FAIL glitch_done: got %b want 0", key_pressed); end
    n_cmp++; if (vcount - v0 != 2) begin n_bad++; $display("FAIL glitch_strobes: got %0d want 2", vcount - v0); end
  endtask

  task automatic test_reset_mid_debounce();
    int cyc;
    int v0;
    align_col(4'b1011);
    v0 = vcount;
    kr = 1; kc = 2; key_down = 1'b1;
    repeat (12) @(negedge CLK);
    n_cmp++; if (vcount != v0) begin n_bad++; $display("FAIL midrst_early: got %0d strobes want 0", vcount - v0); end
    RSTn = 1'b0;
    @(negedge CLK);
    n_cmp++; if (col !== 4'b1110) begin n_bad++; $display("FAIL midrst_col: got %b want 1110", col); end
    n_cmp++; if (key_code !== 4'h0) begin n_bad++; $display("FAIL midrst_code: got %h want 0", key_code); end
    n_cmp++; if (key_pressed !== 1'b0 || key_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_flags: got %b%b want 00", key_pressed, key_valid); end
    @(negedge CLK);
    RSTn = 1'b1;
    wait_valid(cyc);
    n_cmp++; if (cyc != 24) begin n_bad++; $display("FAIL midrst_latency: got %0d want 24", cyc); end
    n_cmp++; if (key_code !== 4'h6) begin n_bad++; $display("FAIL midrst_code2: got %h want 6", key_code); end
    n_cmp++; if (vcount - v0 != 1) begin n_bad++; $display("FAIL midrst_strobes: got %0d want 1", vcount - v0); end
    key_down = 1'b0;
    wait_release();
  endtask

  task automatic test_strobe_rules();
    n_cmp++; if (width_err != 0) begin n_bad++; $display("FAIL strobe_width: got %0d long strobes want 0", width_err); end
    n_cmp++; if (code_err != 0) begin n_bad++; $display("FAIL code_stable: got %0d unstrobed changes want 0", code_err); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi_row();
    test_key15_twice();
    test_reset_mid_debounce();
    test_strobe_rules();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, meaning clock cycles per scan tick (range 2..65535).
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 20, meaning consecutive stable ticks required for press and for release (range 1..255).
REQ-003 SHALL have port CLK  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port RSTn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port row  input  4  keypad row lines, active-low, asynchronous to CLK.
REQ-006 SHALL have port col  output  4  keypad column drive, active-low, exactly one bit low at all times.
REQ-007 SHALL have port key_code  output  4  code of last accepted key, held until the next accepted key.
REQ-008 SHALL have port key_valid  output  1  one-cycle strobe when key_code is updated.
REQ-009 SHALL have port key_pressed  output  1  high while the accepted key remains held, including the release-debounce period.

Function
REQ-010 SHALL pass row through a 2-flop synchronizer; all logic uses only the synchronized value (rs).
REQ-011 SHALL generate tick as a one-cycle pulse every SCAN_DIV cycles from a free-running divider; all FSM sampling occurs only on tick.
REQ-012 SHALL implement FSM states SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-013 SCAN: on tick, if rs has exactly one low bit -> capture column index c and row index r, clear counter, go to DEBOUNCE; otherwise advance c (0->1->2->3->0, wrap) and drive col = ~(1<<c).
REQ-014 SCAN: rs = 4'b1111 or two or more low bits -> treated as no press, scanning continues.
REQ-015 DEBOUNCE: col held; on tick, rs equal to captured pattern -> counter+1; any other value -> counter cleared, return to SCAN with c unchanged.
REQ-016 DEBOUNCE: counter reaching DEBOUNCE_CNT -> go to PRESSED; on the same edge key_code <= {r[1:0], c[1:0]} (r*4+c), key_valid <= 1, key_pressed <= 1.
REQ-017 key_valid SHALL be high for exactly one cycle per accepted press; key_code SHALL change only on that edge.
REQ-018 PRESSED: col held; on tick, rs = 4'b1111 -> clear counter, go to RELEASE; any other value -> stay (no repeat strobes; extra keys ignored).
REQ-019 RELEASE: on tick, rs = 4'b1111 -> counter+1; any low bit -> counter cleared, stay in RELEASE.
REQ-020 RELEASE: counter reaching DEBOUNCE_CNT -> key_pressed <= 0, go to SCAN, col advances from c on the next scanning tick.
REQ-021 Counters SHALL saturate at DEBOUNCE_CNT and never wrap.
REQ-022 Key 15 (row 3, col 3) SHALL be reported like any other key; the block applies no meaning to codes.
REQ-023 Same key pressed twice SHALL yield two key_valid strobes with identical key_code.

Reset
REQ-024 RSTn low SHALL immediately force: state SCAN, c=0, col=4'b1110, key_code=4'h0, key_valid=0, key_pressed=0, divider, counters and synchronizer flops cleared to 0 / 4'b1111 respectively.
REQ-025 Reset asserted mid-debounce or mid-press SHALL discard the press; no key_valid after release of reset until a full new debounce completes.
REQ-026 First tick after reset release SHALL occur SCAN_DIV cycles after the first rising edge with RSTn high.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3)
REQ-027 Reset: RSTn low, row=4'b1111 -> col=4'b1110, key_code=0, key_valid=0, key_pressed=0; col walks 1110,1101,1011,0111,1110 one step per tick.
REQ-028 Clean press key 6 (row1 low while col2 driven, held 10 ticks) -> exactly one key_valid, key_code=4'h6, key_pressed high; release 3 clean ticks -> key_pressed=0, scanning resumes at col 3.
REQ-029 Bounce: row1 toggles every tick for 5 ticks on col2, then stable -> no strobe during bounce; single strobe, key_code=6, after 3 stable ticks.
REQ-030 Two rows low simultaneously (row=4'b1100) -> no key_valid, col continues walking.
REQ-031 Key 15 pressed twice with full release between -> two key_valid strobes, key_code=4'hF both times; release glitch in RELEASE restarts count, no extra strobe.
REQ-032 RSTn pulsed low at counter=2 in DEBOUNCE -> no key_valid; key still held after reset -> strobe only after full 3-tick debounce.
